// File: rtl/qmult_pipe_if.sv
// qmult_pipe bus: operand/enable inputs and
// result/flag/counter outputs for the multiplier lanes.
interface qmult_pipe_if #(
  parameter int N     = 16,
  parameter int LANES = 4,
  parameter int CNT_W = 16
);
  logic               i_ce;
  logic               i_valid;
  logic [LANES*N-1:0] i_multiplicand;
  logic [LANES*N-1:0] i_multiplier;
  logic               i_clr;
  logic               o_valid;
  logic [LANES*N-1:0] o_result;
  logic [LANES-1:0]   o_ovf;
  logic [CNT_W-1:0]   o_ovf_cnt;

  modport master (
    output i_ce, i_valid, i_multiplicand,
    output i_multiplier, i_clr,
    input  o_valid, o_result, o_ovf, o_ovf_cnt
  );

  modport slave (
    input  i_ce, i_valid, i_multiplicand,
    input  i_multiplier, i_clr,
    output o_valid, o_result, o_ovf, o_ovf_cnt
  );
endinterface

// File: rtl/qmult_pipe.sv
// Pipelined multi-lane signed Qm.Q multiplier with
// rounding, saturation, overflow flags and event counter.
module qmult_pipe #(
  parameter int N     = 16,
  parameter int Q     = 8,
  parameter int LANES = 4,
  parameter int PIPE  = 2,
  parameter int ROUND = 1,
  parameter int CNT_W = 16
) (
  input logic         i_clk,
  input logic         i_rst,
  qmult_pipe_if.slave bus
);

  localparam int PW = 2 * N;

  localparam logic signed [PW:0] C_ONE = 1;
  localparam logic signed [PW:0] C_RND =
    (ROUND != 0 && Q > 0) ? (C_ONE << (Q > 0 ? Q - 1 : 0)) : '0;
  localparam logic signed [PW:0] C_MAX =
    {{(N + 2){1'b0}}, {(N - 1){1'b1}}};
  localparam logic signed [PW:0] C_MIN =
    {{(N + 2){1'b1}}, {(N - 1){1'b0}}};
  localparam logic [N-1:0] C_MAXN = {1'b0, {(N - 1){1'b1}}};
  localparam logic [N-1:0] C_MINN = {1'b1, {(N - 1){1'b0}}};

  logic [LANES*PW-1:0] w_prod_bus;
  logic [LANES*PW-1:0] w_sat_bus;
  logic [LANES*N-1:0]  w_res_bus;
  logic [LANES-1:0]    w_ovf;
  logic                w_v_in;
  logic                w_inc;

  logic                r_vout;
  logic [LANES*N-1:0]  r_res;
  logic [LANES-1:0]    r_ovf;
  logic [CNT_W-1:0]    r_cnt;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic signed [N-1:0]  w_a;
    logic signed [N-1:0]  w_b;
    logic signed [PW-1:0] w_p;
    logic signed [PW:0]   w_ext;
    logic signed [PW:0]   w_sum;
    logic signed [PW:0]   w_r;
    logic                 w_hi;
    logic                 w_lo;

    assign w_a = bus.i_multiplicand[k*N +: N];
    assign w_b = bus.i_multiplier[k*N +: N];
    assign w_p = PW'(w_a) * PW'(w_b);
    assign w_prod_bus[k*PW +: PW] = w_p;

    // one extra bit keeps the rounding add from wrapping
    assign w_ext = (PW + 1)'(signed'(w_sat_bus[k*PW +: PW]));
    assign w_sum = w_ext + C_RND;
    assign w_r   = w_sum >>> Q;
    assign w_hi  = w_r > C_MAX;
    assign w_lo  = w_r < C_MIN;

    assign w_res_bus[k*N +: N] =
      w_hi ? C_MAXN : (w_lo ? C_MINN : w_r[N-1:0]);
    assign w_ovf[k] = w_hi | w_lo;
  end

  if (PIPE == 1) begin : g_p1
    assign w_sat_bus = w_prod_bus;
    assign w_v_in    = bus.i_valid;
  end else begin : g_pn
    logic [LANES*PW-1:0] r_pd [PIPE-1];
    logic                r_vd [PIPE-1];

    // product register followed by plain delay stages
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        for (int s = 0; s < PIPE - 1; s++) begin
          r_pd[s] <= '0;
          r_vd[s] <= 1'b0;
        end
      end else if (bus.i_ce) begin
        r_pd[0] <= w_prod_bus;
        r_vd[0] <= bus.i_valid;
        for (int s = 1; s < PIPE - 1; s++) begin
          r_pd[s] <= r_pd[s-1];
          r_vd[s] <= r_vd[s-1];
        end
      end
    end

    assign w_sat_bus = r_pd[PIPE-2];
    assign w_v_in    = r_vd[PIPE-2];
  end

  // output stage: rounded/saturated result, flags gated by valid
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_vout <= 1'b0;
      r_res  <= '0;
      r_ovf  <= '0;
    end else if (bus.i_ce) begin
      r_vout <= w_v_in;
      r_res  <= w_res_bus;
      r_ovf  <= w_v_in ? w_ovf : '0;
    end
  end

  assign w_inc = bus.i_ce & w_v_in & (|w_ovf);

  // saturating count of overflowing beats; clear wins
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (bus.i_clr) begin
      r_cnt <= '0;
    end else if (w_inc && r_cnt != '1) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign bus.o_valid   = r_vout;
  assign bus.o_result  = r_res;
  assign bus.o_ovf     = r_ovf;
  assign bus.o_ovf_cnt = r_cnt;

endmodule

// File: tb/tb_qmult_pipe.sv
// Self-checking bench for qmult_pipe: four configurations
// share one stimulus stream, each checked against a model.
module tb_qmult_pipe;

  localparam int N  = 16;
  localparam int Q  = 8;
  localparam int L  = 4;
  localparam int NC = 4;

  typedef struct packed {
    logic        v;
    logic [63:0] a;
    logic [63:0] b;
  } beat_t;

  function automatic int cfg_pipe(input int i);
    case (i)
      0: return 2;
      1: return 2;
      2: return 1;
      default: return 4;
    endcase
  endfunction

  function automatic int cfg_round(input int i);
    return (i == 0 || i == 2) ? 1 : 0;
  endfunction

  function automatic int cfg_cw(input int i);
    return (i == 1 || i == 2) ? 4 : 16;
  endfunction

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce  = 1'b1;
  logic        clr = 1'b0;
  logic        vld = 1'b0;
  logic [63:0] ma  = '0;
  logic [63:0] mb  = '0;
  logic        chk_en = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  logic        mon_vld [NC];
  logic [63:0] mon_res [NC];
  logic [3:0]  mon_ovf [NC];
  logic [15:0] mon_cnt [NC];

  always #5 clk = ~clk;

  // {ovf, result} for one lane from plain integer arithmetic
  function automatic logic [16:0] lane_res(
    input logic [15:0] a, input logic [15:0] b, input int rnd);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    if (rnd != 0) p = p + (longint'(1) << (Q - 1));
    p = p >>> Q;
    if (p > 32767) return {1'b1, 16'h7FFF};
    if (p < -32768) return {1'b1, 16'h8000};
    return {1'b0, p[15:0]};
  endfunction

  function automatic logic [67:0] exp_beat(
    input beat_t e, input int rnd);
    logic [63:0] r;
    logic [3:0]  o;
    logic [16:0] t;
    for (int k = 0; k < L; k++) begin
      t = lane_res(e.a[k*16 +: 16], e.b[k*16 +: 16], rnd);
      r[k*16 +: 16] = t[15:0];
      o[k] = t[16] & e.v;
    end
    return {o, r};
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < NC; g++) begin : g_cfg
    localparam int P  = cfg_pipe(g);
    localparam int R  = cfg_round(g);
    localparam int CW = cfg_cw(g);

    qmult_pipe_if #(.N(N), .LANES(L), .CNT_W(CW)) u_if ();

    assign u_if.i_ce           = ce;
    assign u_if.i_valid        = vld;
    assign u_if.i_multiplicand = ma;
    assign u_if.i_multiplier   = mb;
    assign u_if.i_clr          = clr;

    qmult_pipe #(
      .N(N), .Q(Q), .LANES(L), .PIPE(P),
      .ROUND(R), .CNT_W(CW)
    ) u_dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (u_if.slave)
    );

    assign mon_vld[g] = u_if.o_valid;
    assign mon_res[g] = u_if.o_result;
    assign mon_ovf[g] = u_if.o_ovf;
    assign mon_cnt[g] = 16'(u_if.o_ovf_cnt);

    beat_t       hist[$];
    int unsigned mcnt;
    beat_t       zb;

    // model: history of enabled samples, output is P-th newest
    initial begin
      zb = '0;
      for (int i = 0; i < P; i++) hist.push_back(zb);
      mcnt = 0;
      forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
          hist.delete();
          for (int i = 0; i < P; i++) hist.push_back(zb);
          mcnt = 0;
        end else begin
          if (ce) begin
            hist.push_front('{v: vld, a: ma, b: mb});
            void'(hist.pop_back());
          end
          if (clr) mcnt = 0;
          else if (ce && hist[P-1].v &&
                   exp_beat(hist[P-1], R)[67:64] != 4'b0 &&
                   mcnt < (32'd1 << CW) - 1)
            mcnt++;
        end
      end
    end

    logic [67:0] e;
    // compare every cycle once checking is armed
    initial forever begin
      @(negedge clk);
      if (chk_en) begin
        e = exp_beat(hist[P-1], R);
        n_chk++;
        if (mon_vld[g] !== hist[P-1].v || mon_res[g] !== e[63:0] ||
            mon_ovf[g] !== e[67:64] || mon_cnt[g] !== 16'(mcnt)) begin
          n_fail++;
          $display("FAIL cfg%0d t=%0t: vld %b/%b res %h/%h ovf %b/%b cnt %0d/%0d",
                   g, $time, mon_vld[g], hist[P-1].v, mon_res[g], e[63:0],
                   mon_ovf[g], e[67:64], mon_cnt[g], mcnt);
        end
      end
    end
  end

  task automatic drive(input logic c, input logic cl, input logic v,
                       input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    ce = c; clr = cl; vld = v; ma = a; mb = b;
  endtask

  localparam logic [63:0] OVA = 64'h0000_0000_0000_7FFF;
  localparam logic [63:0] OVB = 64'h0000_0000_0000_7FFF;

  logic [63:0] snap0, snap3;

  initial begin
    #3 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    for (int g = 0; g < NC; g++) begin
      chk("rst_vld", 64'(mon_vld[g]), 64'd0);
      chk("rst_res", mon_res[g], 64'd0);
      chk("rst_cnt", 64'(mon_cnt[g]), 64'd0);
    end

    // basic products and rounding lanes
    drive(1, 0, 1, 64'hFFFF_0001_FE80_0180, 64'h0080_0080_0200_0200);
    drive(1, 0, 0, 64'd0, 64'd0);
    @(negedge clk);
    chk("basic_r1_res", mon_res[0], 64'h0000_0001_FD00_0300);
    chk("basic_r0_res", mon_res[1], 64'hFFFF_0000_FD00_0300);
    chk("basic_vld", 64'(mon_vld[0]), 64'd1);
    chk("basic_ovf", 64'(mon_ovf[0]), 64'd0);

    // saturation in three lanes, one clean lane
    drive(1, 0, 1, 64'h0100_7FFF_8000_7FFF, 64'h0100_8000_8000_7FFF);
    drive(1, 0, 0, 64'd0, 64'd0);
    @(negedge clk);
    chk("sat_res", mon_res[0], 64'h0100_8000_7FFF_7FFF);
    chk("sat_ovf", 64'(mon_ovf[0]), 64'b0111);
    chk("sat_cnt_once", 64'(mon_cnt[0]), 64'd1);
    repeat (3) drive(1, 0, 0, 64'd0, 64'd0);

    // stream 8 beats with a 3-cycle stall after the 4th
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        drive(0, 0, 1, ~ma, ~mb);
        snap0 = mon_res[0];
        snap3 = mon_res[3];
        drive(0, 0, 1, 64'h1234_5678_9ABC_DEF0, 64'h7FFF_7FFF_7FFF_7FFF);
        drive(0, 0, 0, 64'd0, 64'd0);
      end
      drive(1, 0, 1,
            {16'(i * 1000), 16'(-i * 77), 16'h0100 + 16'(i * 64), 16'(i + 1)},
            {16'h0180, 16'h0300, 16'(i * 4096), 16'hFF00});
      if (i == 4) begin
        chk("stall_hold_p2", mon_res[0], snap0);
        chk("stall_hold_p4", mon_res[3], snap3);
      end
    end
    repeat (6) drive(1, 0, 0, 64'd0, 64'd0);

    // counter saturates in the 4-bit configurations
    repeat (20) drive(1, 0, 1, OVA, OVB);
    repeat (5) drive(1, 0, 0, 64'd0, 64'd0);
    chk("cnt_sat_w4_p2", 64'(mon_cnt[1]), 64'hF);
    chk("cnt_sat_w4_p1", 64'(mon_cnt[2]), 64'hF);

    // clear beats a simultaneous increment
    repeat (3) drive(1, 0, 1, OVA, OVB);
    drive(1, 1, 1, OVA, OVB);
    drive(1, 0, 0, 64'd0, 64'd0);
    for (int g = 0; g < NC; g++)
      chk("clr_prio", 64'(mon_cnt[g]), 64'd0);

    // clear while stalled
    repeat (4) drive(1, 0, 1, OVA, OVB);
    drive(0, 1, 1, OVA, OVB);
    drive(1, 0, 0, 64'd0, 64'd0);
    chk("clr_stalled", 64'(mon_cnt[0]), 64'd0);

    // asynchronous reset with beats in flight
    drive(1, 0, 1, OVA, OVB);
    drive(1, 0, 1, 64'h0000_0000_0200_0300, 64'h0000_0000_0200_0300);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    for (int g = 0; g < NC; g++) begin
      chk("arst_vld", 64'(mon_vld[g]), 64'd0);
      chk("arst_res", mon_res[g], 64'd0);
      chk("arst_cnt", 64'(mon_cnt[g]), 64'd0);
    end
    vld = 1'b0; ma = '0; mb = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) drive(1, 0, 0, 64'd0, 64'd0);
    for (int g = 0; g < NC; g++)
      chk("no_stale", 64'(mon_vld[g]), 64'd0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/qmult_pipe.md
Name: qmult_pipe

Overview:
Pipelined, multi-lane signed fixed-point multiplier for the convolver datapath. Each lane multiplies two N-bit Qm.Q operands and returns an N-bit result in the same format, with selectable rounding, saturation and per-lane overflow flags. A valid bit travels alongside the data. A clock enable stalls the whole pipeline, and a saturating counter records overflow events for debug/statistics.

Parameters:
N, 16, operand/result width (signed two's complement), >=4
Q, 8, fractional bits, 0 <= Q < N
LANES, 4, number of independent parallel multipliers
PIPE, 2, register stages from input to output, >=1 (latency in enabled cycles)
ROUND, 1, 0 = truncate (arithmetic shift, toward -inf), 1 = round-half-up
CNT_W, 16, width of overflow event counter

Ports:
i_clk  input  1  clock, rising edge
i_rst  input  1  reset, asynchronous, active-high
i_ce  input  1  pipeline clock enable; low = all stages hold
i_valid  input  1  input lane data valid
i_multiplicand  input  LANES*N  packed operands A, lane k at [k*N +: N]
i_multiplier  input  LANES*N  packed operands B, same packing
i_clr  input  1  synchronous clear of o_ovf_cnt
o_valid  output  1  o_result/o_ovf valid
o_result  output  LANES*N  packed saturated results, same packing
o_ovf  output  LANES  per-lane saturation flag, aligned with o_result
o_ovf_cnt  output  CNT_W  count of output beats with any lane overflowing

Behaviour:
- Reset (async assert, any time incl. mid-stream): all valid bits, o_result, o_ovf and o_ovf_cnt go to 0 immediately. In-flight data is discarded. First i_valid sampled after deassertion appears PIPE enabled cycles later.
- Per lane: P = signed(A)*signed(B), full 2N bits, 2Q fractional bits.
- ROUND=1 and Q>0: R = (P + 2^(Q-1)) >>> Q, computed in 2N+1 bits (no wrap). ROUND=0 or Q=0: R = P >>> Q.
- Saturation: R > 2^(N-1)-1 -> result 2^(N-1)-1, ovf=1. R < -2^(N-1) -> result -2^(N-1), ovf=1. Otherwise result = R[N-1:0], ovf=0.
- Pipeline: product registered at stage 1. Round/saturate is registered at stage PIPE (PIPE=1: everything combinational into one register). Extra stages are plain delay. Valid shift register of depth PIPE.
- i_ce=1: every stage advances. i_ce=0: every stage, o_valid and o_result hold. Inputs are ignored that cycle, and no bubble is inserted.
- Invalid beats propagate data but o_valid=0. o_ovf is forced 0 when the corresponding valid is 0.
- Latency: exactly PIPE cycles with i_ce=1. Throughput: one beat per enabled cycle.
- o_ovf_cnt increments by 1 on each enabled cycle where the beat being loaded into the output stage is valid and any lane overflows. It saturates at 2^CNT_W-1 (no wrap).
- i_clr=1 clears the counter on the next edge, regardless of i_ce, and has priority over a simultaneous increment.
- Lanes are fully independent. Overflow in one lane never alters another lane's result.

Test Plan:
N=16,Q=8,PIPE=2: lane0 A=0x0180 (1.5), B=0x0200 (2.0); lane1 A=0xFE80 (-1.5), B=0x0200 -> 2 cycles later o_valid=1, lane0=0x0300, lane1=0xFD00, o_ovf=0.
Saturation: A=B=0x7FFF -> 0x7FFF, ovf=1. A=B=0x8000 -> 0x7FFF, ovf=1. A=0x7FFF, B=0x8000 -> 0x8000, ovf=1. o_ovf_cnt increments by 1 per beat, not per lane.
Rounding: A=0x0001, B=0x0080 -> ROUND=1 gives 0x0001, ROUND=0 gives 0x0000. A=0xFFFF, B=0x0080 -> ROUND=1 gives 0x0000, ROUND=0 gives 0xFFFF.
Stall: stream 8 valid beats, drop i_ce for 3 cycles mid-stream -> outputs frozen during stall. All 8 results appear in order, none lost or duplicated. Repeat with PIPE=1 and PIPE=4.
Counter: CNT_W=4, 20 overflowing beats -> o_ovf_cnt sticks at 0xF. i_clr together with an overflowing beat -> counter reads 0.
Reset mid-stream: assert i_rst between clock edges with 2 beats in flight -> o_valid, o_result and o_ovf_cnt go to 0 before the next edge. No stale beat emerges after release.
